// File: rtl/fpa_controller.sv
// Sequencing controller for a floating-point adder datapath: load, add, normalize
// (bounded shift loop), write-back, with an exception exit on any fault.
module fpa_controller #(
  parameter int MAX_NORM = 5
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       start,
  input  logic       add_except,
  input  logic       norm_except,
  input  logic [4:0] mant,
  output logic       load_en,
  output logic       add_en,
  output logic       norm_en,
  output logic       done_en,
  output logic       norm_load,
  output logic       shift_right,
  output logic       shift_left,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [2:0] state
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_ADD   = 3'd2;
  localparam logic [2:0] S_NLOAD = 3'd3;
  localparam logic [2:0] S_NORM  = 3'd4;
  localparam logic [2:0] S_WRITE = 3'd5;
  localparam logic [2:0] S_FIN   = 3'd6;
  localparam logic [2:0] S_EXC   = 3'd7;

  localparam logic [2:0] CNT_LIMIT = 3'(MAX_NORM);

  logic [2:0] state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       shift_need;
  logic       norm_fault;
  logic       do_right;
  logic       do_left;

  // Normalize decision: any fault (flag, zero mantissa, shift budget spent) blocks shifting.
  always_comb begin
    shift_need = mant[4] | (mant[4:3] == 2'b00);
    norm_fault = norm_except | (mant == 5'd0) | (shift_need & (cnt_q == CNT_LIMIT));
    do_right   = (state_q == S_NORM) & ~norm_fault & mant[4];
    do_left    = (state_q == S_NORM) & ~norm_fault & ~mant[4] & ~mant[3];
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_LOAD;
      S_LOAD:  state_d = S_ADD;
      S_ADD:   state_d = S_NLOAD;
      S_NLOAD: state_d = add_except ? S_EXC : S_NORM;
      S_NORM: begin
        if (norm_fault)               state_d = S_EXC;
        else if (!(do_right | do_left)) state_d = S_WRITE;
      end
      S_WRITE: state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      S_EXC:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Shift counter saturates at all-ones so an oversized MAX_NORM can never wrap it.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_IDLE || state_q == S_NLOAD)
      cnt_d = 3'd0;
    else if ((do_right | do_left) && cnt_q != 3'b111)
      cnt_d = cnt_q + 3'd1;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign load_en     = (state_q == S_LOAD);
  assign add_en      = (state_q == S_ADD);
  assign norm_en     = (state_q == S_NLOAD) | (state_q == S_NORM);
  assign norm_load   = (state_q == S_NLOAD);
  assign done_en     = (state_q == S_WRITE);
  assign shift_right = do_right;
  assign shift_left  = do_left;
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_FIN) | (state_q == S_EXC);
  assign err         = (state_q == S_EXC);
  assign state       = state_q;

endmodule

// File: tb/tb_fpa_controller.sv
// Bench for fpa_controller: table of directed operations, randomized operations
// against an operation-level reference model, and hand-written reset/back-to-back sequences.
module tb_fpa_controller;

  localparam int MAXN = 5;

  logic       clk = 1'b0;
  logic       clr, start, add_except, norm_except;
  logic [4:0] mant;
  logic       load_en, add_en, norm_en, done_en, norm_load;
  logic       shift_right, shift_left, busy, done, err;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  fpa_controller #(.MAX_NORM(MAXN)) dut (
    .clk(clk), .clr(clr), .start(start), .add_except(add_except),
    .norm_except(norm_except), .mant(mant), .load_en(load_en), .add_en(add_en),
    .norm_en(norm_en), .done_en(done_en), .norm_load(norm_load),
    .shift_right(shift_right), .shift_left(shift_left), .busy(busy),
    .done(done), .err(err), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] m0;
    bit         ae;
    bit         hold;
    int         ne;
    int         exp_d;
    bit         exp_err;
  } vec_t;

  vec_t tbl[12];

  // Reference model results for one operation
  int         m_d;
  bit         m_err;
  int         m_nn;
  logic [4:0] m_ms[16];
  bit         m_sr[16];
  bit         m_sl[16];

  function automatic logic [10:0] obs();
    return {load_en, add_en, norm_en, done_en, norm_load, shift_right, shift_left,
            busy, done, err, (state == 3'd0)};
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Walks the normalize rules on a mantissa value with plain arithmetic.
  task automatic model(input logic [4:0] m0, input bit ae, input bit hold, input int ne);
    logic [4:0] m;
    int cnt, i;
    bit fin, need;
    for (int j = 0; j < 16; j++) begin m_ms[j] = '0; m_sr[j] = 0; m_sl[j] = 0; end
    if (ae) begin
      m_d = 4; m_err = 1; m_nn = 0;
    end else begin
      m = m0; cnt = 0; i = 0; fin = 0;
      while (!fin && i < 15) begin
        m_ms[i] = m;
        need = (m >= 5'd16) || (m < 5'd8);
        if (i == ne || m == 5'd0 || (need && cnt == MAXN)) begin
          m_d = 4 + i + 1; m_err = 1; m_nn = i + 1; fin = 1;
        end else if (m >= 5'd16) begin
          m_sr[i] = 1; cnt++; i++;
          if (!hold) m = m / 2;
        end else if (m < 5'd8) begin
          m_sl[i] = 1; cnt++; i++;
          if (!hold) m = m * 2;
        end else begin
          m_d = 4 + i + 2; m_err = 0; m_nn = i + 1; fin = 1;
        end
      end
    end
  endtask

  // Runs one operation from IDLE, checking every cycle until back in IDLE.
  task automatic run_op(input logic [4:0] m0, input bit ae, input bit hold, input int ne,
                        output int od, output bit oerr);
    logic [10:0] exp;
    bit nc;
    model(m0, ae, hold, ne);
    start = 1'b1; add_except = 1'($urandom); norm_except = 1'($urandom); mant = 5'($urandom);
    @(posedge clk); #1;
    od = -1; oerr = 0;
    for (int k = 1; k <= m_d + 1; k++) begin
      nc = (k >= 4) && (k < 4 + m_nn);
      start       = (k < m_d) ? 1'($urandom_range(0, 1)) : 1'b0;
      add_except  = (k == 3) ? ae : 1'($urandom);
      norm_except = nc ? (k - 4 == ne) : 1'($urandom);
      mant        = nc ? m_ms[k-4] : 5'($urandom);
      @(negedge clk);
      exp = {k == 1, k == 2, (k == 3) || nc, !m_err && (k == m_d - 1), k == 3,
             nc && m_sr[k-4 < 0 ? 0 : k-4], nc && m_sl[k-4 < 0 ? 0 : k-4],
             k <= m_d, k == m_d, (k == m_d) && m_err, k == m_d + 1};
      chk($sformatf("op_cycle%0d", k), 16'(obs()), 16'(exp));
      if (done && od < 0) begin od = k; oerr = err; end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int od;
    bit oerr;
    logic [4:0] rm;
    bit rae, rhold;
    int rne;

    tbl[0]  = '{5'b01011, 1'b0, 1'b0, -1, 6,  1'b0};
    tbl[1]  = '{5'b10110, 1'b0, 1'b0, -1, 7,  1'b0};
    tbl[2]  = '{5'b00010, 1'b0, 1'b0, -1, 8,  1'b0};
    tbl[3]  = '{5'b01011, 1'b1, 1'b0, -1, 4,  1'b1};
    tbl[4]  = '{5'b00000, 1'b0, 1'b0, -1, 5,  1'b1};
    tbl[5]  = '{5'b01011, 1'b0, 1'b0,  0, 5,  1'b1};
    tbl[6]  = '{5'b00010, 1'b0, 1'b0,  1, 6,  1'b1};
    tbl[7]  = '{5'b00001, 1'b0, 1'b0, -1, 9,  1'b0};
    tbl[8]  = '{5'b00001, 1'b0, 1'b1, -1, 10, 1'b1};
    tbl[9]  = '{5'b10000, 1'b0, 1'b1, -1, 10, 1'b1};
    tbl[10] = '{5'b11111, 1'b0, 1'b0, -1, 7,  1'b0};
    tbl[11] = '{5'b11000, 1'b0, 1'b0,  2, 7,  1'b0};

    clr = 1'b1; start = 1'b0; add_except = 1'b0; norm_except = 1'b0; mant = 5'd0;
    #3;
    chk("reset_outputs", 16'(obs()), 16'(11'b1));
    chk("reset_state", 16'(state), 16'(0));
    @(posedge clk); #1;
    clr = 1'b0;

    foreach (tbl[i]) begin
      run_op(tbl[i].m0, tbl[i].ae, tbl[i].hold, tbl[i].ne, od, oerr);
      chk($sformatf("tbl%0d_done_cycle", i), 16'(od), 16'(tbl[i].exp_d));
      chk($sformatf("tbl%0d_err", i), 16'(oerr), 16'(tbl[i].exp_err));
    end

    for (int n = 0; n < 30; n++) begin
      rm    = 5'($urandom);
      rae   = ($urandom_range(0, 7) == 0);
      rhold = ($urandom_range(0, 7) == 0);
      rne   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : -1;
      run_op(rm, rae, rhold, rne, od, oerr);
      chk($sformatf("rnd%0d_done_cycle", n), 16'(od), 16'(m_d));
      chk($sformatf("rnd%0d_err", n), 16'(oerr), 16'(m_err));
    end

    // start held high: second launch only after one IDLE cycle
    start = 1'b1; mant = 5'b01011; add_except = 1'b0; norm_except = 1'b0;
    @(posedge clk); #1;
    for (int k = 1; k <= 14; k++) begin
      if (k == 14) start = 1'b0;
      @(negedge clk);
      chk($sformatf("held_start_cycle%0d", k), 16'({load_en, done, busy}),
          16'({k == 1 || k == 8, k == 6 || k == 13, !(k == 7 || k == 14)}));
      @(posedge clk); #1;
    end

    // clr asserted mid-NORM aborts at once with no done pulse
    start = 1'b1; mant = 5'b10110;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("clr_pre_norm_shift", 16'(shift_right), 16'(1));
    #2 clr = 1'b1;
    #1 chk("clr_immediate", 16'(obs()), 16'(11'b1));
    repeat (2) begin
      @(negedge clk);
      chk("clr_held", 16'(obs()), 16'(11'b1));
    end
    @(posedge clk); #1;
    clr = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("clr_released_idle", 16'(obs()), 16'(11'b1));
      @(posedge clk); #1;
    end
    run_op(5'b01011, 1'b0, 1'b0, -1, od, oerr);
    chk("post_clr_done_cycle", 16'(od), 16'(6));
    chk("post_clr_err", 16'(oerr), 16'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
